// File: rtl/ps2_scancode_decoder_pkg.sv
// rtl/ps2_scancode_decoder_pkg.sv - shared scancode constants, FSM encodings and event type
//
// Purpose: scancode byte values, decoder state encodings and the key event
// record shared by the PS/2 scancode decoder and its frame checker.
package ps2_scancode_decoder_pkg;

  // Prefix and overrun bytes
  localparam logic [7:0] CODE_E0   = 8'hE0;
  localparam logic [7:0] CODE_F0   = 8'hF0;
  localparam logic [7:0] CODE_OVR0 = 8'h00;
  localparam logic [7:0] CODE_OVR1 = 8'hFF;

  // Extended arrow keys (all arrive behind an E0 prefix)
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  // Decoder states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GOT_E0   = 2'd1;
  localparam logic [1:0] ST_GOT_F0   = 2'd2;
  localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  function automatic logic is_prefix(input logic [7:0] d);
    return (d == CODE_E0) || (d == CODE_F0);
  endfunction

  function automatic logic is_overrun(input logic [7:0] d);
    return (d == CODE_OVR0) || (d == CODE_OVR1);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_frame_check.sv
// rtl/ps2_scancode_decoder_frame_check.sv - combinational PS/2 11-bit frame validator
//
// Purpose: checks start, stop and odd parity of one PS/2 frame and extracts
// the data byte. Purely combinational so it can sit on any PS/2 path.
// Ports:
//   frame_i  11-bit frame: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
//   ok_o     1 when start=0, stop=1 and data+parity has odd parity
//   data_o   data byte
module ps2_frame_check (
  input  logic [10:0] frame_i,
  output logic        ok_o,
  output logic [7:0]  data_o
);

  assign data_o = frame_i[8:1];
  assign ok_o   = (frame_i[0] == 1'b0) && (frame_i[10] == 1'b1) && (^frame_i[9:1] == 1'b1);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 frame validation, prefix stripping and arrow key levels
//
// Purpose: consumes completed PS/2 frames, strips E0/F0 prefixes, emits one
// key event per key action, tracks held state of the four extended arrow
// keys and pulses frame/sequence errors.
// Ports:
//   sys_clk, reset       clock, asynchronous active-high reset
//   frame_valid, frame   one-cycle frame strobe and 11-bit frame
//   key_valid            one-cycle event strobe for key_code/key_ext/key_break
//   key_code/ext/break   last emitted event (held until the next key_valid)
//   up/down/left/right   held levels of E0-75/E0-72/E0-6B/E0-74
//   frame_error          one-cycle pulse on bad start/stop/parity
//   seq_error            one-cycle pulse on bad prefix order, overrun or timeout
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMER_W        = 17
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [10:0] frame,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_break,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        frame_error,
  output logic        seq_error
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic             ok;
  logic [7:0]       data;

  logic [1:0]       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic             key_valid_q, key_valid_d;
  key_evt_t         evt_q, evt_d;
  logic [3:0]       arrows_q, arrows_d;   // {right, left, down, up}
  logic             frame_error_q, frame_error_d;
  logic             seq_error_q, seq_error_d;

  ps2_frame_check u_frame_check (
    .frame_i (frame),
    .ok_o    (ok),
    .data_o  (data)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    key_valid_d   = 1'b0;
    evt_d         = evt_q;
    arrows_d      = arrows_q;
    frame_error_d = 1'b0;
    seq_error_d   = 1'b0;

    if (frame_valid) begin
      // Every decoded frame either enters a fresh prefix state or returns to
      // IDLE, so the timer restarts from zero in all cases.
      timer_d = '0;
      if (!ok) begin
        frame_error_d = 1'b1;
        state_d       = ST_IDLE;
      end else if (is_overrun(data)) begin
        seq_error_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (data == CODE_E0) begin
              state_d = ST_GOT_E0;
            end else if (data == CODE_F0) begin
              state_d = ST_GOT_F0;
            end else begin
              key_valid_d = 1'b1;
              evt_d       = '{code: data, ext: 1'b0, brk: 1'b0};
            end
          end
          ST_GOT_E0: begin
            if (data == CODE_F0) begin
              state_d = ST_GOT_E0F0;
            end else if (data == CODE_E0) begin
              state_d = ST_GOT_E0;
            end else begin
              key_valid_d = 1'b1;
              evt_d       = '{code: data, ext: 1'b1, brk: 1'b0};
              state_d     = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            state_d = ST_IDLE;
            if (is_prefix(data)) begin
              seq_error_d = 1'b1;
            end else begin
              key_valid_d = 1'b1;
              evt_d       = '{code: data, ext: 1'b0, brk: 1'b1};
            end
          end
          default: begin
            state_d = ST_IDLE;
            if (is_prefix(data)) begin
              seq_error_d = 1'b1;
            end else begin
              key_valid_d = 1'b1;
              evt_d       = '{code: data, ext: 1'b1, brk: 1'b1};
            end
          end
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // A frame in the same cycle takes the branch above, so a frame landing
      // exactly on the last timer count is decoded rather than timed out.
      if (timer_q == TIMER_LAST) begin
        seq_error_d = 1'b1;
        state_d     = ST_IDLE;
        timer_d     = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    // Only extended events touch the arrow levels; make sets, break clears.
    if (key_valid_d && evt_d.ext) begin
      case (evt_d.code)
        KEY_UP:    arrows_d[0] = ~evt_d.brk;
        KEY_DOWN:  arrows_d[1] = ~evt_d.brk;
        KEY_LEFT:  arrows_d[2] = ~evt_d.brk;
        KEY_RIGHT: arrows_d[3] = ~evt_d.brk;
        default:   arrows_d    = arrows_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      key_valid_q   <= 1'b0;
      evt_q         <= '0;
      arrows_q      <= '0;
      frame_error_q <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      key_valid_q   <= key_valid_d;
      evt_q         <= evt_d;
      arrows_q      <= arrows_d;
      frame_error_q <= frame_error_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = evt_q.code;
  assign key_ext     = evt_q.ext;
  assign key_break   = evt_q.brk;
  assign up          = arrows_q[0];
  assign down        = arrows_q[1];
  assign left        = arrows_q[2];
  assign right       = arrows_q[3];
  assign frame_error = frame_error_q;
  assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - scoreboard bench for the PS/2 scancode decoder
module tb_ps2_scancode_decoder;

  localparam int T = 40;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [10:0] frame = '0;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_break;
  logic        up, down, left, right;
  logic        frame_error;
  logic        seq_error;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       kv;
    logic       fe;
    logic       se;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got;

  ps2_scancode_decoder #(
    .TIMEOUT_CYCLES (T),
    .TIMER_W        (6)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame       (frame),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .frame_error (frame_error),
    .seq_error   (seq_error)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic exp_key(input logic [7:0] c, input logic e, input logic b);
    exp_q.push_back('{kv: 1'b1, fe: 1'b0, se: 1'b0, code: c, ext: e, brk: b});
  endtask

  task automatic exp_ferr();
    exp_q.push_back('{kv: 1'b0, fe: 1'b1, se: 1'b0, code: 8'h00, ext: 1'b0, brk: 1'b0});
  endtask

  task automatic exp_serr();
    exp_q.push_back('{kv: 1'b0, fe: 1'b0, se: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0});
  endtask

  task automatic send_raw(input logic [10:0] f);
    @(negedge sys_clk);
    frame = f;
    frame_valid = 1'b1;
    @(negedge sys_clk);
    frame_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] d);
    send_raw(mk_frame(d));
  endtask

  task automatic check_arrows(input string tag, input logic [3:0] exp);
    check_eq(tag, {28'd0, right, left, down, up}, {28'd0, exp});
  endtask

  // Every output pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (!reset && (key_valid || frame_error || seq_error)) begin
      mon_got = {key_valid, frame_error, seq_error,
                 key_valid ? {key_code, key_ext, key_break} : 10'b0};
      if (exp_q.size() == 0)
        check_eq("unexpected_event", 32'(mon_got), 32'd0);
      else
        check_eq("event", 32'(mon_got), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    repeat (2) @(negedge sys_clk);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_key_code", 32'(key_code), 32'd0);
    check_eq("rst_flags", {29'd0, key_ext, key_break, frame_error | seq_error}, 32'd0);
    check_arrows("rst_arrows", 4'b0000);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Plain make
    exp_key(8'h1C, 1'b0, 1'b0);
    send_raw(11'h438);
    check_arrows("plain_arrows", 4'b0000);

    // Extended up make, then left make: both held
    exp_key(8'h75, 1'b1, 1'b0);
    send_raw(11'h5C0);
    send_raw(11'h4EA);
    check_arrows("up_make", 4'b0001);
    exp_key(8'h6B, 1'b1, 1'b0);
    send(8'hE0);
    send(8'h6B);
    check_arrows("left_make", 4'b0101);

    // Extended up break
    exp_key(8'h75, 1'b1, 1'b1);
    send_raw(11'h5C0);
    send_raw(11'h7E0);
    send_raw(11'h4EA);
    check_arrows("up_break", 4'b0100);
    repeat (3) @(negedge sys_clk);
    check_eq("code_hold", {23'd0, key_code, key_ext}, {23'd0, 8'h75, 1'b1});

    // Plain break
    exp_key(8'h1C, 1'b0, 1'b1);
    send(8'hF0);
    send(8'h1C);

    // Bad parity discards a pending E0
    exp_ferr();
    send_raw(11'h5C0);
    send_raw(11'h638);
    exp_key(8'h1C, 1'b0, 1'b0);
    send_raw(11'h438);
    // Bad start and bad stop bits
    exp_ferr();
    send_raw(11'h439);
    exp_ferr();
    send_raw(11'h038);

    // Prefix timeout, then a clean non-extended decode
    exp_serr();
    send_raw(11'h5C0);
    repeat (T + 5) @(negedge sys_clk);
    check_eq("timeout_drained", 32'(exp_q.size()), 32'd0);
    exp_key(8'h1C, 1'b0, 1'b0);
    send_raw(11'h438);

    // Frame lands on the final timer count: decoded, no timeout
    exp_key(8'h75, 1'b1, 1'b0);
    @(negedge sys_clk);
    frame = 11'h5C0;
    frame_valid = 1'b1;
    @(negedge sys_clk);
    frame_valid = 1'b0;
    repeat (T - 1) @(negedge sys_clk);
    frame = 11'h4EA;
    frame_valid = 1'b1;
    @(negedge sys_clk);
    frame_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_arrows("boundary_up", 4'b0101);

    // Frame one cycle too late: timeout first, then a plain code
    exp_serr();
    exp_key(8'h75, 1'b0, 1'b0);
    @(negedge sys_clk);
    frame = 11'h5C0;
    frame_valid = 1'b1;
    @(negedge sys_clk);
    frame_valid = 1'b0;
    repeat (T) @(negedge sys_clk);
    frame = 11'h4EA;
    frame_valid = 1'b1;
    @(negedge sys_clk);
    frame_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_arrows("late_no_change", 4'b0101);

    // Overrun codes and illegal prefix order
    exp_serr();
    send_raw(11'h600);
    exp_serr();
    send(8'hFF);
    exp_serr();
    send(8'hF0);
    send(8'hF0);
    exp_serr();
    send(8'hE0);
    send(8'hF0);
    send(8'hE0);

    // Repeated E0, then right make; E1 is an ordinary code
    exp_key(8'h74, 1'b1, 1'b0);
    send(8'hE0);
    send(8'hE0);
    send(8'h74);
    check_arrows("right_make", 4'b1101);
    exp_key(8'hE1, 1'b0, 1'b0);
    send(8'hE1);
    check_arrows("e1_no_change", 4'b1101);

    // Down make, pending E0, then asynchronous reset
    exp_key(8'h72, 1'b1, 1'b0);
    send(8'hE0);
    send(8'h72);
    check_arrows("down_make", 4'b1111);
    send(8'hE0);
    #2 reset = 1'b1;
    #1;
    check_arrows("async_rst_arrows", 4'b0000);
    check_eq("async_rst_code", 32'(key_code), 32'd0);
    check_eq("async_rst_flags", {28'd0, key_valid, key_ext, key_break, frame_error | seq_error}, 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;
    exp_key(8'h75, 1'b0, 1'b0);
    send_raw(11'h4EA);
    check_arrows("post_rst_arrows", 4'b0000);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge sys_clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Downstream of the PS/2 receive controller and shift register. Consumes each completed 11-bit frame, validates start/parity/stop, and strips the E0 (extended) and F0 (break) prefixes. Emits one key event per key action and keeps held-state levels for the four arrow keys used by game control. Errors are reported as single-cycle pulses. The game FSM sees only clean key events.

Parameters:
TIMEOUT_CYCLES, 100000, sys_clk cycles allowed between a prefix byte and the byte that completes it (2 ms at 50 MHz)
TIMER_W, 17, width of the prefix timeout counter; must satisfy 2^TIMER_W > TIMEOUT_CYCLES

Ports:
sys_clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high; clears all state and outputs
frame_valid  in  1  one-cycle pulse: frame holds a complete 11-bit frame
frame  in  11  frame[0]=start, frame[8:1]=data (LSB at bit 1), frame[9]=parity, frame[10]=stop
key_valid  out  1  one-cycle pulse: key_code/key_ext/key_break are valid
key_code  out  8  scancode byte with prefixes removed
key_ext  out  1  code was preceded by E0
key_break  out  1  release event (code was preceded by F0)
up, down, left, right  out  1 each  held level of the extended arrow keys E0-75, E0-72, E0-6B, E0-74
frame_error  out  1  one-cycle pulse: bad start, stop or parity
seq_error  out  1  one-cycle pulse: illegal prefix order, overrun code, or prefix timeout

Behaviour:
- Reset, asynchronous: state=IDLE, timer=0, all outputs 0.
- Frame check, combinational on frame: ok = (frame[0]==0) && (frame[10]==1) && (^frame[9:1]==1), i.e. odd parity.
- Latency: all outputs are registered. key_valid, the error pulses and the arrow levels update on the sys_clk edge that samples frame_valid=1. key_code, key_ext and key_break hold their values until the next key_valid.
- Bad frame: frame_error=1 for one cycle, state returns to IDLE, any pending prefix is discarded, no key event.
- Overrun: data 0x00 or 0xFF in any state gives seq_error, IDLE, no key event.
- State machine, per good frame with data byte d:
  - IDLE: d=E0 -> GOT_E0. d=F0 -> GOT_F0. Other d -> emit make (ext=0, break=0), stay IDLE.
  - GOT_E0: d=F0 -> GOT_E0F0. d=E0 -> stay GOT_E0 and restart timer. Other d -> emit (ext=1, break=0), go IDLE.
  - GOT_F0: d=E0 or F0 -> seq_error, IDLE. Other d -> emit (ext=0, break=1), go IDLE.
  - GOT_E0F0: d=E0 or F0 -> seq_error, IDLE. Other d -> emit (ext=1, break=1), go IDLE.
- Timer:
  - Cleared on every transition into a non-IDLE state, and on re-entry into GOT_E0.
  - Counts while state!=IDLE.
  - When timer reaches TIMEOUT_CYCLES-1 with no frame_valid: seq_error pulse, IDLE, timer cleared.
  - In IDLE the timer holds 0.
- Simultaneous frame_valid and timeout in the same cycle: the frame wins and is decoded against the current state; no timeout is reported.
- Arrow levels:
  - Updated only on an emitted event with ext=1 and key_code in {75,72,6B,74}.
  - Make sets the matching level; break clears it.
  - Non-arrow events leave the levels unchanged. Several arrows may be held at once.
- E1 (Pause) bytes are not special: each is emitted as an ordinary code.
- frame_valid is never asserted on consecutive cycles (the upstream receiver guarantees this). The block needs no input buffering.

Decomposition:
- Shared include ps2_scancodes.vh: localparams CODE_E0=8'hE0, CODE_F0=8'hF0, CODE_OVR0=8'h00, CODE_OVR1=8'hFF, KEY_UP=8'h75, KEY_DOWN=8'h72, KEY_LEFT=8'h6B, KEY_RIGHT=8'h74, and the state encodings.
- One natural sub-module: ps2_frame_check. Combinational: frame in; ok and data[7:0] out. It is reused by any future host-to-device path.

Test Plan:
- Frame 0x438 (data 1C) -> next edge key_valid=1, key_code=1C, ext=0, break=0; arrows unchanged.
- Frames 0x5C0 (E0) then 0x4EA (75) -> key_valid only after the second frame: code=75, ext=1, break=0, up=1. Then 0x5C0, 0x7E0 (F0), 0x4EA -> break=1, up=0.
- Frame 0x438 with parity bit flipped (0x638) -> frame_error pulse, no key_valid; a pending E0 sent beforehand is discarded.
- Frame 0x5C0 then no frames for TIMEOUT_CYCLES -> exactly one seq_error pulse, state IDLE. A following 0x438 decodes as non-extended 1C.
- Frame 0x600 (data 00) -> seq_error, no event. Sequence F0,F0 -> seq_error on the second F0.
- Assert reset mid-sequence (after E0, up held) -> all outputs 0 immediately. A subsequent 0x4EA decodes with ext=0.
